// File: rtl/fifo_mem.sv
// Dual-port storage for sync_fifo: synchronous write port, registered read port.
// The array itself is never reset; only the read-data register clears on reset.
module fifo_mem #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // A read to the address being written in the same cycle returns the old word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with internal pointers, occupancy count, programmable
// almost-full/almost-empty flags and one-cycle overflow/underflow pulses.
module sync_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_TH      = (2 ** ADDR_WIDTH) - 2,
    parameter int AE_TH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] ONE       = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] AF_LVL    = AF_TH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_LVL    = AE_TH[ADDR_WIDTH:0];

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic                wr_accept;
    logic                rd_accept;

    // A full FIFO still takes a write when a read frees a slot in the same cycle;
    // an empty FIFO never forwards a same-cycle write to the read side.
    assign wr_accept = wr_en && (!full || rd_en);
    assign rd_accept = rd_en && !empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = wr_en && !wr_accept;
        underflow_d = rd_en && !rd_accept;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + ONE;
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + ONE;
        end
        if (wr_accept && !rd_accept) begin
            count_d = count_q + ONE;
        end else if (rd_accept && !wr_accept) begin
            count_d = count_q - ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_accept),
        .wr_addr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data_i (data_in),
        .rd_en_i   (rd_accept),
        .rd_addr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data_o (data_out)
    );

    assign count        = count_q;
    assign full         = (count_q == DEPTH_CNT);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_LVL);
    assign almost_empty = (count_q <= AE_LVL);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: a queue-based reference model predicts the
// state after every edge, and an independent monitor compares the DUT against it.
module tb_sync_fifo;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    typedef struct {
        int          cnt;
        logic [15:0] dout;
        logic        ovf;
        logic        udf;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    int total;
    int bad;

    logic [15:0] model[$];
    logic [15:0] expDout;
    exp_t        sbq[$];

    sync_fifo #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .AF_TH      (AF),
        .AE_TH      (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .data_in      (data_in),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and predict the state after the next rising edge.
    task automatic applyStimulus(input logic rstVal, input logic w, input logic r, input logic [15:0] d);
        exp_t e;
        bit   rdAcc;
        bit   wrAcc;
        @(negedge clk);
        rst     = rstVal;
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        if (!rstVal) begin
            model.delete();
            expDout = 16'h0000;
            e.ovf   = 1'b0;
            e.udf   = 1'b0;
        end else begin
            rdAcc = r && (model.size() != 0);
            wrAcc = w && ((model.size() != DEPTH) || r);
            if (rdAcc) expDout = model.pop_front();
            if (wrAcc) model.push_back(d);
            e.ovf = w && !wrAcc;
            e.udf = r && !rdAcc;
        end
        e.cnt  = model.size();
        e.dout = expDout;
        sbq.push_back(e);
    endtask

    // Monitor: sample just after each rising edge and compare against the oldest prediction.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                checkOutput("count",        int'(count),        e.cnt);
                checkOutput("data_out",     int'(data_out),     int'(e.dout));
                checkOutput("overflow",     int'(overflow),     int'(e.ovf));
                checkOutput("underflow",    int'(underflow),    int'(e.udf));
                checkOutput("full",         int'(full),         int'(e.cnt == DEPTH));
                checkOutput("empty",        int'(empty),        int'(e.cnt == 0));
                checkOutput("almost_full",  int'(almost_full),  int'(e.cnt >= AF));
                checkOutput("almost_empty", int'(almost_empty), int'(e.cnt <= AE));
            end
        end
    end

    initial begin : stimulus
        total   = 0;
        bad     = 0;
        expDout = 16'h0000;
        rst     = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = '0;

        // Reset values
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);

        // Fill, overflow, drain
        for (int i = 1; i <= 16; i++) applyStimulus(1'b1, 1'b1, 1'b0, 16'(i));
        applyStimulus(1'b1, 1'b1, 1'b0, 16'hBEEF);
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 1'b1, 16'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0);

        // Wrap-around
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, 16'h0500 + 16'(i));
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b1, 16'h0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, 16'h0A00 + 16'(i));
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b1, 16'h0);

        // Simultaneous read and write while full
        for (int i = 1; i <= 16; i++) applyStimulus(1'b1, 1'b1, 1'b0, 16'(i));
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h1234);
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 1'b1, 16'h0);

        // Simultaneous read and write while empty
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h00A5);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0);

        // Asynchronous reset in the middle of a cycle
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 16'h0300 + 16'(i));
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0305);
        @(posedge clk);
        #3;
        wr_en = 1'b0;
        rst   = 1'b0;
        #1;
        checkOutput("async_count", int'(count),    0);
        checkOutput("async_empty", int'(empty),    1);
        checkOutput("async_dout",  int'(data_out), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0077);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0);

        // Randomized traffic with phases biased towards filling and draining
        for (int p = 0; p < 8; p++) begin
            int wrPct;
            wrPct = (p % 2 == 0) ? 80 : 25;
            for (int i = 0; i < 60; i++) begin
                applyStimulus(1'b1,
                              1'($urandom_range(99, 0) < wrPct),
                              1'($urandom_range(99, 0) < (100 - wrPct)),
                              16'($urandom));
            end
        end
        for (int i = 0; i < 40; i++) begin
            applyStimulus(($urandom_range(39, 0) == 0) ? 1'b0 : 1'b1,
                          1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 16'($urandom));
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);

        for (int i = 0; i < 20 && sbq.size() > 0; i++) @(posedge clk);
        #2;
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: got %0d pending want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Parametrised synchronous FIFO that succeeds the externally addressed `memory_buffer`. Read and write pointers are generated internally, so the user supplies only `wr_en`/`rd_en`. Data width and depth are configurable. Occupancy count, programmable almost-full/almost-empty flags, and overflow/underflow error pulses are added. The block buffers data between a producer and a consumer in the same clock domain.

## Interface
- `DATA_WIDTH`, default 16: word width.
- `ADDR_WIDTH`, default 4: address width; DEPTH = 2**ADDR_WIDTH.
- `AF_TH`, default DEPTH-2: `almost_full` asserts when count >= AF_TH.
- `AE_TH`, default 2: `almost_empty` asserts when count <= AE_TH.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `wr_en`  in  1  write request.
- `rd_en`  in  1  read request.
- `data_in`  in  DATA_WIDTH  write data.
- `data_out`  out  DATA_WIDTH  registered read data.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `almost_full`  out  1  count >= AF_TH.
- `almost_empty`  out  1  count <= AE_TH.
- `count`  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  one-cycle pulse: a write was rejected.
- `underflow`  out  1  one-cycle pulse: a read was rejected.

## Operation
- **Pointers:** `wr_ptr` and `rd_ptr` are ADDR_WIDTH+1 bits. The low ADDR_WIDTH bits address memory, and the MSB is a wrap bit. Pointers increment modulo 2**(ADDR_WIDTH+1), so memory addressing wraps naturally from DEPTH-1 to 0.
- **Write accept:** `wr_en && (!full || rd_en)`.
  - When full, a write is accepted only if a read occurs in the same cycle.
  - An accepted write stores `data_in` at `wr_ptr` and increments `wr_ptr`.
- **Read accept:** `rd_en && !empty`.
  - An accepted read loads `mem[rd_ptr]` into `data_out` and increments `rd_ptr`.
  - A read is never satisfied by a same-cycle write: on an empty FIFO, a simultaneous read and write accepts the write and rejects the read.
- **Count:** +1 for write only, −1 for read only, unchanged for both or neither. It never exceeds DEPTH and never drops below 0.
- **Flags:** `full`, `empty`, `almost_full` and `almost_empty` are decoded combinationally from registered `count`, so they are glitch-free relative to the clock edge.
- **`data_out`:** holds its value when no read is accepted, including rejected reads.
- **Error pulses:**
  - `overflow` is 1 for exactly the cycle after the edge at which a write was rejected.
  - `underflow` behaves the same for a rejected read.
  - Back-to-back rejections keep the pulse high continuously.
- **Reset** (`rst` low, at any time, independent of `clk`):
  - Pointers, `count`, `data_out`, `overflow` and `underflow` clear to 0.
  - Therefore `empty`=1, `almost_empty`=1, `full`=0, `almost_full`=0.
  - Memory contents are not cleared. Requests are ignored while `rst` is low.

## Timing
- Write-to-visible: a word written at edge N is readable at edge N+1. `data_out` shows it after edge N+1, i.e. 2-edge latency from write to data on an empty FIFO.
- Read latency: 1 cycle, with `data_out` valid after the edge that accepts `rd_en`.
- Flags and `count` reflect the accepted operations of edge N immediately after edge N.
- Reset assertion takes effect immediately. Deassertion takes effect at the first rising edge after `rst` goes high.
- Sustained throughput is one write and one read per cycle.

## Structure
- No shared package. DEPTH is a localparam derived from ADDR_WIDTH.
- Parameter legality: 0 <= AE_TH < AF_TH <= DEPTH.
- Sub-module `fifo_mem`: a DEPTH x DATA_WIDTH dual-port RAM with a synchronous write port and a registered read port, no reset on the array.
- `sync_fifo` holds the pointers, count, flags and error pulses.

## Test plan
Defaults throughout (DATA_WIDTH 16, ADDR_WIDTH 4, DEPTH 16, AF_TH 14, AE_TH 2).
1. **Reset values:** hold `rst`=0 for 2 cycles → `count`=0, `empty`=1, `almost_empty`=1, `full`=0, `almost_full`=0, `data_out`=0, no error pulses.
2. **Fill and drain:**
   - Write 0x0001..0x0010 → `almost_empty` drops at `count`=3, `almost_full` rises at `count`=14, `full`=1 at `count`=16.
   - Write 0xBEEF → one-cycle `overflow`, `count` stays 16.
   - Read 16 → `data_out` returns 0x0001..0x0010 in order, then `empty`=1.
3. **Wrap-around:** write 10 words, read 10, write 10 words 0x0A00..0x0A09, read 10 → output is 0x0A00..0x0A09 in order, `count` returns to 0.
4. **Simultaneous on full:** with 16 words (0x0001..0x0010), assert `rd_en`+`wr_en` with 0x1234 → `data_out`=0x0001, `count`=16, no `overflow`. The 16th subsequent read returns 0x1234.
5. **Simultaneous on empty:** assert `rd_en`+`wr_en` with 0x00A5 → `underflow` pulses, `data_out` unchanged, `count`=1. The next read gives 0x00A5.
6. **Reset mid-operation:** at `count`=5, drive `rst` low mid-cycle → `count`=0, `empty`=1, `data_out`=0 before the next edge. After release, write 0x0077 and read → 0x0077.
